// File: rtl/mem_addr_arbiter_pkg.sv
// Shared types and constants for the memory address arbiter.
// Holds the FSM state type, default sizing and the pointer width helper.
package mem_addr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbState_e;

    localparam int DEFAULT_N_CH  = 4;
    localparam int DEFAULT_WIDTH = 32;

    // A single-channel index still needs one bit to stay a legal vector.
    function automatic int ptrWidth(input int nCh);
        return (nCh > 1) ? $clog2(nCh) : 1;
    endfunction

endpackage

// File: rtl/mem_addr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first unmasked request at or after
// the pointer wins, with the search wrapping from the last channel to 0.
module rr_pick
    import mem_addr_arbiter_pkg::*;
#(
    parameter int N_CH  = DEFAULT_N_CH,
    parameter int PTR_W = ptrWidth(N_CH)
) (
    input  logic [N_CH-1:0]  request_i,
    input  logic [N_CH-1:0]  mask_i,
    input  logic [PTR_W-1:0] pointer_i,
    output logic [N_CH-1:0]  winner_o,
    output logic             valid_o
);

    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        winner_o = '0;
        valid_o  = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < N_CH; k++) begin
            // The pointer is always below N_CH, so one subtraction wraps it.
            sum = {1'b0, pointer_i} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N_CH)) begin
                sum = sum - (PTR_W+1)'(N_CH);
            end
            idx = sum[PTR_W-1:0];
            if (!valid_o && request_i[idx] && !mask_i[idx]) begin
                winner_o[idx] = 1'b1;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_addr_arbiter.sv
// Round-robin address arbiter: picks one channel, presents its address to
// memory until accepted, then hands over to the next winner with no bubble.
module mem_addr_arbiter
    import mem_addr_arbiter_pkg::*;
#(
    parameter int N_CH  = DEFAULT_N_CH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_CH-1:0]         req_i,
    input  logic [N_CH*WIDTH-1:0]   addr_i,
    input  logic                    force_en,
    // One bit wider than a channel index so out-of-range selects are expressible.
    input  logic [ptrWidth(N_CH):0] force_sel,
    output logic [WIDTH-1:0]        mem_addr_o,
    output logic                    mem_valid_o,
    input  logic                    mem_ready_i,
    output logic [N_CH-1:0]         grant_o,
    output logic [N_CH-1:0]         done_o
);

    localparam int PTR_W = ptrWidth(N_CH);

    arbState_e        state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] memAddr_q, memAddr_d;
    logic [N_CH-1:0]  grant_q, grant_d;
    logic             forced_q, forced_d;

    logic [N_CH-1:0]  pickReq;
    logic [N_CH-1:0]  pickMask;
    logic [N_CH-1:0]  pickWinner;
    logic             pickValid;
    logic [PTR_W-1:0] grantIdx;
    logic [PTR_W-1:0] nextPtr;
    logic [WIDTH-1:0] winAddr;
    logic             fire;

    assign fire        = (state_q == BUSY) && mem_ready_i;
    assign mem_addr_o  = memAddr_q;
    assign mem_valid_o = (state_q == BUSY);
    assign grant_o     = grant_q;
    assign done_o      = fire ? grant_q : '0;

    // Forced mode replaces the request vector by a one-hot of force_sel.
    always_comb begin
        pickReq = req_i;
        if (force_en) begin
            pickReq = '0;
            if (force_sel < (PTR_W+1)'(N_CH)) begin
                pickReq[force_sel[PTR_W-1:0]] = 1'b1;
            end
        end
    end

    always_comb begin
        grantIdx = '0;
        winAddr  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant_q[k]) begin
                grantIdx = PTR_W'(k);
            end
            if (pickWinner[k]) begin
                winAddr = addr_i[k*WIDTH +: WIDTH];
            end
        end
        nextPtr = (grantIdx == PTR_W'(N_CH-1)) ? '0 : grantIdx + 1'b1;
    end

    rr_pick #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .request_i (pickReq),
        .mask_i    (pickMask),
        .pointer_i (ptr_d),
        .winner_o  (pickWinner),
        .valid_o   (pickValid)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        memAddr_d = memAddr_q;
        grant_d   = grant_q;
        forced_d  = forced_q;
        pickMask  = '0;
        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    state_d   = BUSY;
                    grant_d   = pickWinner;
                    memAddr_d = winAddr;
                    forced_d  = force_en;
                end
            end
            BUSY: begin
                if (mem_ready_i) begin
                    // Completing channel cannot win the back-to-back slot.
                    pickMask = grant_q;
                    if (!forced_q) begin
                        ptr_d = nextPtr;
                    end
                    if (pickValid) begin
                        grant_d   = pickWinner;
                        memAddr_d = winAddr;
                        forced_d  = force_en;
                    end else begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        forced_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            memAddr_q <= '0;
            grant_q   <= '0;
            forced_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            memAddr_q <= memAddr_d;
            grant_q   <= grant_d;
            forced_q  <= forced_d;
        end
    end

endmodule

// File: tb/tb_mem_addr_arbiter.sv
// Self-checking bench for mem_addr_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_mem_addr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] addrBus;
    logic           forceEn;
    logic [2:0]     forceSel;
    logic           ready;
    logic [W-1:0]   memAddr;
    logic           memValid;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;

    int checks = 0;
    int passes = 0;

    // Reference model state: one outstanding transfer at most.
    bit           mBusy;
    bit           mForced;
    int           mCh;
    int           mPtr;
    logic [W-1:0] mAddr;

    typedef struct {
        logic [N-1:0] req;
        logic         ready;
        logic         expValid;
        logic [W-1:0] expAddr;
        logic [N-1:0] expGrant;
        logic [N-1:0] expDone;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    mem_addr_arbiter #(.N_CH(N), .WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_i       (req),
        .addr_i      (addrBus),
        .force_en    (forceEn),
        .force_sel   (forceSel),
        .mem_addr_o  (memAddr),
        .mem_valid_o (memValid),
        .mem_ready_i (ready),
        .grant_o     (grant),
        .done_o      (done)
    );

    function automatic logic [N-1:0] effReq();
        logic [N-1:0] r;
        r = req;
        if (forceEn) begin
            r = '0;
            if (int'(forceSel) < N) r[forceSel[1:0]] = 1'b1;
        end
        return r;
    endfunction

    function automatic int pickModel(logic [N-1:0] r, int maskCh, int start);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (start + k) % N;
            if (r[c] && c != maskCh) return c;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mBusy   = 1'b0;
        mForced = 1'b0;
        mCh     = 0;
        mPtr    = 0;
        mAddr   = '0;
    endtask

    task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic checkOutput(input string name, input logic expValid, input logic [W-1:0] expAddr,
                               input logic [N-1:0] expGrant, input logic [N-1:0] expDone,
                               input logic checkAddr);
        checkVal({name, ".valid"}, W'(memValid), W'(expValid));
        checkVal({name, ".grant"}, W'(grant), W'(expGrant));
        checkVal({name, ".done"}, W'(done), W'(expDone));
        if (checkAddr) checkVal({name, ".addr"}, memAddr, expAddr);
    endtask

    task automatic modelCheck(input string name);
        logic [N-1:0] g;
        g = '0;
        if (mBusy) g[mCh] = 1'b1;
        checkOutput(name, mBusy, mAddr, g, ready ? g : '0, mBusy);
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic fe, input logic [2:0] fs, input logic rd);
        req      = r;
        forceEn  = fe;
        forceSel = fs;
        ready    = rd;
        #1;
    endtask

    task automatic clockEdge();
        logic [N-1:0] eff;
        int w;
        eff = effReq();
        if (!mBusy) begin
            w = pickModel(eff, -1, mPtr);
            if (w >= 0) begin
                mBusy = 1'b1; mCh = w; mAddr = addrBus[w*W +: W]; mForced = forceEn;
            end
        end else if (ready) begin
            if (!mForced) mPtr = (mCh + 1) % N;
            w = pickModel(eff, mCh, mPtr);
            if (w >= 0) begin
                mCh = w; mAddr = addrBus[w*W +: W]; mForced = forceEn;
            end else begin
                mBusy = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setKnownAddrs();
        addrBus = {32'h40, 32'h30, 32'h20, 32'h10};
    endtask

    initial begin
        vecs[0] = '{4'b0001, 1'b0, 1'b0, 32'h00, 4'b0000, 4'b0000};
        vecs[1] = '{4'b0001, 1'b0, 1'b1, 32'h10, 4'b0001, 4'b0000};
        vecs[2] = '{4'b1111, 1'b1, 1'b1, 32'h10, 4'b0001, 4'b0001};
        vecs[3] = '{4'b1111, 1'b1, 1'b1, 32'h20, 4'b0010, 4'b0010};
        vecs[4] = '{4'b1111, 1'b1, 1'b1, 32'h30, 4'b0100, 4'b0100};
        vecs[5] = '{4'b1111, 1'b1, 1'b1, 32'h40, 4'b1000, 4'b1000};
        vecs[6] = '{4'b1111, 1'b0, 1'b1, 32'h10, 4'b0001, 4'b0000};
        vecs[7] = '{4'b0000, 1'b1, 1'b1, 32'h10, 4'b0001, 4'b0001};
        vecs[8] = '{4'b0000, 1'b0, 1'b0, 32'h00, 4'b0000, 4'b0000};

        reset_n = 1'b0;
        setKnownAddrs();
        modelReset();
        applyStimulus('0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset", 1'b0, '0, '0, '0, 1'b1);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].req, 1'b0, 3'd0, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expAddr,
                        vecs[i].expGrant, vecs[i].expDone, vecs[i].expValid);
            modelCheck($sformatf("vec%0dModel", i));
            clockEdge();
        end

        // Stall with changing addresses: held address, no done until ready.
        applyStimulus(4'b1000, 1'b0, 3'd0, 1'b0);
        modelCheck("stallReq");
        clockEdge();
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < N; c++) addrBus[c*W +: W] = $urandom;
            applyStimulus(4'b1000, 1'b0, 3'd0, 1'b0);
            checkVal("stallAddr", memAddr, 32'h40);
            checkVal("stallDone", W'(done), 32'h0);
            modelCheck("stallModel");
            clockEdge();
        end
        applyStimulus(4'b0000, 1'b0, 3'd0, 1'b1);
        checkVal("stallRelease", W'(done), 32'h8);
        modelCheck("stallReleaseModel");
        clockEdge();

        // Forced select of channel 2 with no requests; pointer must stay at 0.
        setKnownAddrs();
        applyStimulus(4'b0000, 1'b1, 3'd2, 1'b0);
        modelCheck("forceReq");
        clockEdge();
        applyStimulus(4'b0000, 1'b1, 3'd2, 1'b0);
        checkVal("forceGrant", W'(grant), 32'h4);
        checkVal("forceAddr", memAddr, 32'h30);
        modelCheck("forceModel");
        clockEdge();
        applyStimulus(4'b0000, 1'b0, 3'd0, 1'b1);
        checkVal("forceDone", W'(done), 32'h4);
        modelCheck("forceDoneModel");
        clockEdge();
        applyStimulus(4'b1111, 1'b0, 3'd0, 1'b0);
        modelCheck("ptrKeptReq");
        clockEdge();
        applyStimulus(4'b1111, 1'b0, 3'd0, 1'b1);
        checkVal("forcePtrKept", W'(grant), 32'h1);
        modelCheck("ptrKeptModel");
        clockEdge();
        applyStimulus(4'b0000, 1'b0, 3'd0, 1'b1);
        modelCheck("drain");
        clockEdge();

        // Out-of-range forced select: no grant at all.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'b1111, 1'b1, 3'd5, 1'b0);
            checkVal("forceRangeValid", W'(memValid), 32'h0);
            checkVal("forceRangeGrant", W'(grant), 32'h0);
            modelCheck("forceRangeModel");
            clockEdge();
        end

        // Reset mid-transfer, then the lowest requester wins from pointer 0.
        applyStimulus(4'b0110, 1'b0, 3'd0, 1'b0);
        modelCheck("midResetReq");
        clockEdge();
        applyStimulus(4'b0110, 1'b0, 3'd0, 1'b1);
        checkVal("midResetBusy", W'(memValid), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("midReset", 1'b0, '0, '0, '0, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(4'b1010, 1'b0, 3'd0, 1'b0);
        modelCheck("afterReset");
        clockEdge();
        applyStimulus(4'b1010, 1'b0, 3'd0, 1'b0);
        checkVal("afterResetGrant", W'(grant), 32'h2);
        modelCheck("afterResetModel");
        clockEdge();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N; c++) addrBus[c*W +: W] = $urandom;
            applyStimulus(N'($urandom), $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
                          1'($urandom));
            modelCheck($sformatf("rand%0d", i));
            clockEdge();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_addr_arbiter.md
MEM_ADDR_ARBITER -- requirements
Module: mem_addr_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of address source channels (2..16).
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning the address/data width per channel.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port req_i, input, N_CH, meaning per-channel request, level, held until the matching done_o.
REQ-006 The block SHALL have port addr_i, input, N_CH*WIDTH, meaning flattened channel addresses, channel k at bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port force_en, input, 1, meaning legacy direct-select mode: bypasses arbitration.
REQ-008 The block SHALL have port force_sel, input, clog2(N_CH), meaning channel index used when force_en=1.
REQ-009 The block SHALL have port mem_addr_o, output, WIDTH, meaning registered selected address.
REQ-010 The block SHALL have port mem_valid_o, output, 1, meaning mem_addr_o is valid and held stable.
REQ-011 The block SHALL have port mem_ready_i, input, 1, meaning memory accepts; transfer occurs when mem_valid_o and mem_ready_i are both 1.
REQ-012 The block SHALL have port grant_o, output, N_CH, meaning one-hot channel owning the current transfer; all-zero when idle.
REQ-013 The block SHALL have port done_o, output, N_CH, meaning a one-cycle pulse on the channel whose transfer completed.

Function
REQ-014 The block SHALL implement states IDLE and BUSY.
REQ-015 In IDLE, with a winner available, the block SHALL latch addr_i[winner] into mem_addr_o, set grant_o, and assert mem_valid_o on the next edge, giving 1-cycle latency from req to valid.
REQ-016 With force_en=1, the winner SHALL be force_sel regardless of req_i.
REQ-017 With force_en=1 and force_sel>=N_CH, there SHALL be no winner, and the block SHALL stay idle.
REQ-018 With force_en=0, the winner SHALL be the first requesting channel at or after the round-robin pointer, wrapping from N_CH-1 to 0.
REQ-019 In BUSY, mem_addr_o and grant_o SHALL be held stable, ignoring addr_i, req_i and force_* changes, until the transfer completes.
REQ-020 On completion, done_o[granted] SHALL pulse for exactly that cycle, and the pointer SHALL become granted+1 mod N_CH.
REQ-021 On completion, the block SHALL re-arbitrate in the same cycle with the completing channel masked.
REQ-022 If a winner exists on completion, the block SHALL remain in BUSY with the new grant and address on the next edge, with no idle bubble.
REQ-023 If no winner exists on completion, the block SHALL return to IDLE and clear mem_valid_o and grant_o.
REQ-024 The force_en path SHALL NOT advance the round-robin pointer.
REQ-025 Simultaneous requests SHALL be resolved only by the pointer; a deasserted req while in BUSY SHALL NOT abort the transfer.

Reset
REQ-026 While reset_n=0, the block SHALL asynchronously force the state to IDLE and the pointer, mem_addr_o, mem_valid_o, grant_o and done_o to 0, including mid-transfer.
REQ-027 After reset_n is released, the block SHALL arbitrate from the first clk edge.

Structure
REQ-028 A shared package SHALL hold the state enum, the default N_CH and WIDTH constants, and the pointer width function.
REQ-029 Winner selection SHALL be one combinational sub-module, rr_pick, with inputs request, mask and pointer, and outputs one-hot winner and valid.

Verification
REQ-030 The bench SHALL cover: reset, then req_i=0001 with addr0=0x10 -> mem_valid_o=1, mem_addr_o=0x10, grant_o=0001 one cycle later.
REQ-031 The bench SHALL cover: req_i=1111 held, mem_ready_i=1 -> grants 0001,0010,0100,1000,0001 on consecutive transfers, with no idle cycle.
REQ-032 The bench SHALL cover: mem_ready_i=0 for 5 cycles while addr_i changes -> mem_addr_o is unchanged, and done_o stays 0 until ready.
REQ-033 The bench SHALL cover: force_en=1, force_sel=2, req_i=0 -> grant_o=0100, mem_addr_o=addr2, with the pointer unchanged afterwards.
REQ-034 The bench SHALL cover: force_sel=5 with N_CH=4 -> no grant and mem_valid_o stays 0.
REQ-035 The bench SHALL cover: reset_n dropped while in BUSY -> all outputs 0 immediately, and the first grant after release goes to the lowest requesting channel.
